// File: rtl/input_pkg.sv
// Shared defaults and board channel map for input_conditioner instances.
// Latency: none, constants and a compile-time helper only.
// Backpressure: none.
package input_pkg;

  // Default synchroniser depth, 1 ms debounce tick at a 25 MHz pixel clock, ticks to accept
  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PRESCALE_25MHZ_1MS  = 25000;
  localparam int DEF_DEBOUNCE_TICKS      = 4;

  // Board wiring: which conditioner channel carries which button
  localparam int CH_RESET    = 0;
  localparam int CH_NEW_GAME = 1;
  localparam int CH_UP       = 2;
  localparam int CH_PAUSE    = 3;
  localparam int CH_DOWN     = 4;

  // Counter width for a modulus of n; never narrower than one bit so n=1 still elaborates
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: synchroniser chain, tick-qualified debouncer, polarity flip, edge pulses.
// Latency: SYNC_STAGES + (DEBOUNCE_TICKS-1)*PRESCALE + 1..PRESCALE cycles, pin to level.
// Backpressure: none; free-running, outputs are levels and one-cycle pulses.
module debounce_channel
  import input_pkg::*;
#(
  parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic IDLE_LEVEL     = 1'b1,
  parameter logic INVERT         = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic pin_raw,
  output logic level,
  output logic pressed,
  output logic released
);

  localparam int            CW        = cnt_width(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic          LEVEL_RST = IDLE_LEVEL ^ INVERT;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syn;
  logic                   stable;
  logic [CW-1:0]          cnt;
  logic                   lvl_q;

  assign syn = sync_q[SYNC_STAGES-1];

  // Metastability chain: pin enters at bit 0, the top bit is the synchronised level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw};
  end

  // Accept a new level only after DEBOUNCE_TICKS ticks of uninterrupted disagreement;
  // any cycle of agreement (tick or not) restarts qualification
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= IDLE_LEVEL;
      cnt    <= '0;
    end else if (syn == stable) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        stable <= syn;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable ^ INVERT;

  // Previous level for edge detection; reset value matches level so reset never pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lvl_q <= LEVEL_RST;
    else          lvl_q <= level;
  end

  assign pressed  =  level & ~lvl_q;
  assign released = ~level &  lvl_q;

endmodule

// File: rtl/input_conditioner.sv
// N-channel pin conditioner: sync, debounce on a shared prescaled tick, normalise, edge pulses.
// Latency: SYNC_STAGES + (DEBOUNCE_TICKS-1)*PRESCALE + 1..PRESCALE cycles, pin to level.
// Backpressure: none; free-running, tick exported as a shared time base.
module input_conditioner
  import input_pkg::*;
#(
  parameter int           N              = 4,
  parameter int           SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int           PRESCALE       = DEF_PRESCALE_25MHZ_1MS,
  parameter int           DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic [N-1:0] IDLE_LEVEL     = '1,
  parameter logic [N-1:0] INVERT         = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] pin_raw,
  output logic [N-1:0] level,
  output logic [N-1:0] pressed,
  output logic [N-1:0] released,
  output logic         tick
);

  localparam int            PW       = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  // Free-running prescaler counting 0..PRESCALE-1 and wrapping to 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                pre_cnt <= '0;
    else if (pre_cnt == PRE_LAST) pre_cnt <= '0;
    else                         pre_cnt <= pre_cnt + 1'b1;
  end

  // Unregistered compare; gated by reset so PRESCALE=1 still reads 0 while held in reset
  assign tick = reset_n & (pre_cnt == PRE_LAST);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .IDLE_LEVEL     (IDLE_LEVEL[i]),
      .INVERT         (INVERT[i])
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .pin_raw  (pin_raw[i]),
      .level    (level[i]),
      .pressed  (pressed[i]),
      .released (released[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random pin activity,
// every cycle compared against a behavioural model of the debounce rules.
module tb_input_conditioner;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int DT = 3;
  localparam logic [N-1:0] IDLE = 4'b1111;
  localparam logic [N-1:0] INV  = 4'b0111;
  localparam int LAT_MIN = S + (DT - 1) * P + 1;
  localparam int LAT_MAX = S + (DT - 1) * P + P;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] pin_raw = 4'b0000;
  logic [N-1:0] level, pressed, released;
  logic         tick;

  input_conditioner #(
    .N(N), .SYNC_STAGES(S), .PRESCALE(P), .DEBOUNCE_TICKS(DT),
    .IDLE_LEVEL(IDLE), .INVERT(INV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pin_raw(pin_raw),
    .level(level), .pressed(pressed), .released(released), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_press [N];
  int n_rel   [N];

  // Behavioural model: pins seen through an S-deep delay line, a tick every P-th cycle
  // since reset release, and a new level accepted after DT ticks of continuous disagreement
  logic [N-1:0] m_stable;
  logic [N-1:0] m_prev;
  int           m_run [N];
  int           m_cyc;
  logic [N-1:0] m_q [$];
  logic [N-1:0] exp_lvl;
  logic         exp_tick;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d..%0d", name, cyc, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    m_stable = IDLE;
    m_prev   = IDLE ^ INV;
    m_cyc    = 0;
    m_q.delete();
    for (int k = 0; k < S; k++) m_q.push_back(IDLE);
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] syn;
    logic         tk;
    syn    = m_q[0];
    tk     = ((m_cyc % P) == P - 1);
    m_prev = m_stable ^ INV;
    for (int i = 0; i < N; i++) begin
      if (syn[i] == m_stable[i]) m_run[i] = 0;
      else if (tk) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DT) begin
          m_stable[i] = syn[i];
          m_run[i]    = 0;
        end
      end
    end
    void'(m_q.pop_front());
    m_q.push_back(pin_raw);
    m_cyc = m_cyc + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare every cycle on the falling edge and count observed pulses
  initial begin
    for (int i = 0; i < N; i++) begin
      n_press[i] = 0;
      n_rel[i]   = 0;
    end
    forever begin
      @(negedge clk);
      exp_lvl  = m_stable ^ INV;
      exp_tick = reset_n && ((m_cyc % P) == P - 1);
      chk("level",    level,    exp_lvl);
      chk("pressed",  pressed,  exp_lvl & ~m_prev);
      chk("released", released, ~exp_lvl & m_prev);
      chk("tick", {{(N-1){1'b0}}, tick}, {{(N-1){1'b0}}, exp_tick});
      for (int i = 0; i < N; i++) begin
        if (pressed[i])  n_press[i]++;
        if (released[i]) n_rel[i]++;
      end
    end
  end

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Wait for level[ch]==val and check the cycle count since start; returns on a falling edge
  task automatic wait_level(input int ch, input logic val, input int start, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (level[ch] === val) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: level[%0d] never reached %b within 40 cycles", name, ch, val);
    end else begin
      chk_range(name, cyc - start, LAT_MIN, LAT_MAX);
    end
  endtask

  int t0, b0, b1, b2, b3, r0, r1, r2, r3;

  initial begin
    // Reset with pins away from idle: sync chain and outputs hold reset values
    step(3);
    chk("rst_level",    level,    4'b1000);
    chk("rst_pressed",  pressed,  4'b0000);
    chk("rst_released", released, 4'b0000);
    chk("rst_tick", {3'b000, tick}, 4'b0000);
    pin_raw = 4'b1111;
    step(1);
    reset_n = 1'b1;
    b0 = n_press[0] + n_press[1] + n_press[2] + n_press[3];
    r0 = n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3];
    step(50);
    chk_int("idle_press_pulses", n_press[0] + n_press[1] + n_press[2] + n_press[3] - b0, 0);
    chk_int("idle_rel_pulses",   n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3] - r0, 0);
    chk("idle_level", level, 4'b1000);

    // Clean press on ch0 at a random prescaler phase
    step($urandom_range(0, 3));
    b0 = n_press[0]; r0 = n_rel[0];
    pin_raw[0] = 1'b0;
    t0 = cyc;
    wait_level(0, 1'b1, t0, "ch0_press_lat");
    chk("ch0_press_pulse", pressed, 4'b0001);
    step(10);
    chk_int("ch0_press_cnt", n_press[0] - b0, 1);
    chk_int("ch0_rel_cnt",   n_rel[0] - r0, 0);
    chk("ch0_levels", level, 4'b1001);

    // Bounce on ch1: 5-cycle phases never qualify, then settle low
    b1 = n_press[1]; r1 = n_rel[1];
    pin_raw[1] = 1'b0; step(5);
    pin_raw[1] = 1'b1; step(5);
    pin_raw[1] = 1'b0; step(5);
    pin_raw[1] = 1'b1; step(5);
    chk_int("ch1_bounce_press", n_press[1] - b1, 0);
    pin_raw[1] = 1'b0;
    t0 = cyc;
    wait_level(1, 1'b1, t0, "ch1_settle_lat");
    step(10);
    chk_int("ch1_press_cnt", n_press[1] - b1, 1);
    chk_int("ch1_rel_cnt",   n_rel[1] - r1, 0);

    // 8-cycle glitch on ch2 is one cycle short of acceptance
    b2 = n_press[2]; r2 = n_rel[2];
    pin_raw[2] = 1'b0; step(8);
    pin_raw[2] = 1'b1; step(30);
    chk_int("ch2_glitch_press", n_press[2] - b2, 0);
    chk_int("ch2_glitch_rel",   n_rel[2] - r2, 0);
    chk("ch2_levels", level, 4'b1011);

    // Non-inverted ch3: pin low releases, pin high presses
    b3 = n_press[3]; r3 = n_rel[3];
    pin_raw[3] = 1'b0;
    t0 = cyc;
    wait_level(3, 1'b0, t0, "ch3_release_lat");
    chk("ch3_release_pulse", released, 4'b1000);
    step(5);
    chk_int("ch3_rel_cnt", n_rel[3] - r3, 1);
    pin_raw[3] = 1'b1;
    t0 = cyc;
    wait_level(3, 1'b1, t0, "ch3_press_lat");
    step(5);
    chk_int("ch3_press_cnt", n_press[3] - b3, 1);
    chk("ch3_levels", level, 4'b1011);

    // Simultaneous press on ch0 and ch1
    pin_raw[1:0] = 2'b11;
    step(30);
    chk("simul_released", level, 4'b1000);
    step($urandom_range(0, 3));
    b0 = n_press[0]; b1 = n_press[1];
    pin_raw[1:0] = 2'b00;
    t0 = cyc;
    wait_level(0, 1'b1, t0, "simul_lat");
    chk("simul_pulse", pressed, 4'b0011);
    step(5);
    chk_int("simul_ch0_cnt", n_press[0] - b0, 1);
    chk_int("simul_ch1_cnt", n_press[1] - b1, 1);

    // Reset pulsed mid-qualification: acceptance restarts from reset release
    pin_raw[1:0] = 2'b11;
    step(30);
    step($urandom_range(0, 3));
    b0 = n_press[0]; b1 = n_press[1];
    pin_raw[1:0] = 2'b00;
    step(6);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    t0 = cyc;
    wait_level(0, 1'b1, t0, "rst_restart_lat");
    chk("rst_restart_pulse", pressed, 4'b0011);
    step(5);
    chk_int("rst_ch0_cnt", n_press[0] - b0, 1);
    chk_int("rst_ch1_cnt", n_press[1] - b1, 1);
    chk("rst_restart_levels", level, 4'b1011);

    // Random pin activity with occasional resets, checked by the per-cycle model compare
    for (int seg = 0; seg < 150; seg++) begin
      pin_raw = pin_raw ^ N'($urandom_range(0, (1 << N) - 1));
      step($urandom_range(1, 20));
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        step($urandom_range(1, 2));
        reset_n = 1'b1;
      end
    end
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
